lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller between the pipeline memory stage and the single-port data bus. It accepts one pipeline request at a time and instantiates `mem_prep` to derive the word address, write lanes and misalignment. It then runs a request/grant/response transaction on the data bus and returns sign- or zero-extended load data. It is the sequencer that makes `mem_prep` outputs bus-legal and stalls the pipeline while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 64: cycles in REQ+WAIT before a bus timeout fault; only used with `LSU_BUS_TIMEOUT_EN`; legal range 2..255.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: pipeline request valid.
- `req_ready_o` out 1: controller can accept a request.
- `req_write_i` in 1: 1 = store, 0 = load.
- `req_width_i` in `mem_width_e`: BYTE/HALF/WORD.
- `req_unsigned_i` in 1: zero-extend load (LBU/LHU).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and faults.
- `rsp_err_o` out 1: fault (misaligned, bus error, timeout).
- `rsp_misaligned_o` out 1: fault cause is misalignment.
- `bus_req_o` out 1: bus request.
- `bus_gnt_i` in 1: bus grant.
- `bus_addr_o` out 32: word-aligned address.
- `bus_we_o` out 1: write enable.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-replicated write data.
- `bus_rvalid_i` in 1: response/write-ack valid.
- `bus_rdata_i` in 32: read word.
- `bus_err_i` in 1: bus error, qualified by `bus_rvalid_i`.
- `busy_o` out 1: state != IDLE.

## Operation
- States: IDLE, REQ, WAIT, RESP, FAULT.
- IDLE
  - `req_ready_o`=1.
  - On `req_valid_i`: register addr[1:0], width, unsigned and write, plus the `mem_prep` word address, write data and strobe.
  - If `mem_prep` flags the access illegal: → FAULT.
  - Otherwise: → REQ.
- REQ
  - `bus_req_o`=1 with `bus_addr_o`, `bus_we_o`, `bus_be_o` and `bus_wdata_o` from registers, held stable until `bus_gnt_i`.
  - On grant: → WAIT.
- WAIT
  - Waits for `bus_rvalid_i`.
  - On `bus_rvalid_i`: register extracted data and error, then → RESP.
- RESP
  - `rsp_valid_o`=1 for one cycle, then → IDLE.
- FAULT
  - `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_misaligned_o`=1 for one cycle; → IDLE.
  - No bus activity.
- Byte enables
  - Stores: `mem_prep` strobe.
  - Loads: 4'b1111.
- Load extraction, with idx = registered addr[1:0]:
  - BYTE: (rdata >> 8·idx)[7:0], extended.
  - HALF: (rdata >> 8·idx)[15:0], extended.
  - WORD: rdata unchanged.
  - Extension is sign unless `req_unsigned_i` was set.
- Stores: `bus_rvalid_i` acts as the write ack; `rsp_rdata_o`=0.
- Bus error: `rsp_err_o`=1, `rsp_rdata_o`=0, `rsp_misaligned_o`=0.
- `bus_rvalid_i` outside WAIT is ignored. This covers stale responses after reset.
- `bus_gnt_i` outside REQ is ignored.
- `req_valid_i` outside IDLE is ignored; the pipeline must hold it.

## Timing
- Reset: state IDLE; all registered outputs 0.
  - `req_ready_o` follows state, so it is 1 from the first cycle after reset.
  - Reset mid-transaction abandons it: no response, `bus_req_o` drops next cycle.
- Bus outputs are registered and driven only in REQ; they are 0 elsewhere.
- Minimum latency: accept at cycle 0, `bus_req_o` at 1, grant at 1, rvalid at 2, `rsp_valid_o` at 3.
- Misaligned latency: accept at cycle 0, `rsp_valid_o` at 1.
- Grant and rvalid in the same cycle: the rvalid is ignored. rvalid is legal no earlier than the cycle after grant.
- One outstanding transaction. Next accept no earlier than the cycle after RESP/FAULT, so throughput is one access per 4 cycles minimum.

## Configuration
- `LSU_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`: → RESP with `rsp_err_o`=1, `rsp_rdata_o`=0; `bus_req_o` drops.
  - Any later `bus_rvalid_i` is ignored.
- `LSU_BUS_TIMEOUT_EN` undefined:
  - No counter; REQ and WAIT wait indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- LB signed, addr 0x0000_1003, `bus_rdata_i`=0x80FF_1234 → `bus_addr_o`=0x1000, `bus_be_o`=4'b1111, `bus_we_o`=0; `rsp_rdata_o`=0xFFFF_FF80, `rsp_valid_o` 3 cycles after accept with immediate grant/rvalid.
- LHU addr 0x2002, `bus_rdata_i`=0xBEEF_0000 → `rsp_rdata_o`=0x0000_BEEF, `rsp_err_o`=0.
- SB addr 0x3001, wdata 0x0000_00AB → `bus_wdata_o`=0xABAB_ABAB, `bus_be_o`=4'b0010, `bus_we_o`=1; after ack, `rsp_rdata_o`=0.
- SW addr 0x4002 → no `bus_req_o` ever; next cycle `rsp_valid_o`=`rsp_err_o`=`rsp_misaligned_o`=1.
- Grant delayed 3 cycles → bus outputs stable throughout REQ, `req_ready_o`=0. rvalid in the grant cycle is ignored. rvalid with `bus_err_i`=1 → `rsp_err_o`=1, `rsp_rdata_o`=0, `rsp_misaligned_o`=0.
- `LSU_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, never respond → timeout error response, then a late rvalid is ignored. Separately, `rst_ni`=0 in WAIT → IDLE next cycle, no `rsp_valid_o`, a stale rvalid is ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one pipeline memory request at a time,
// prepares it with mem_prep (word address, lane strobes, replicated store
// data, alignment check), runs a request/grant/response transaction on the
// single-port data bus and returns extended load data as a one-cycle pulse.
// Optional feature macro: LSU_BUS_TIMEOUT_EN enables a bus timeout counter
// limited by TIMEOUT_CYCLES (legal range 2..255).

package lsu_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_width_e;
endpackage

module mem_prep
    import lsu_pkg::*;
(
    input  logic [31:0] addr_i,
    input  mem_width_e  width_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] word_addr_o,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Word-align the address, place store lanes and flag illegal alignment
    always_comb begin
        word_addr_o  = {addr_i[31:2], 2'b00};
        strb_o       = 4'b0000;
        wdata_o      = 32'h0000_0000;
        misaligned_o = 1'b0;
        case (width_i)
            MEM_BYTE: begin
                strb_o  = 4'b0001 << addr_i[1:0];
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_HALF: begin
                strb_o       = 4'b0011 << addr_i[1:0];
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_i[0];
            end
            MEM_WORD: begin
                strb_o       = 4'b1111;
                wdata_o      = wdata_i;
                misaligned_o = (addr_i[1:0] != 2'b00);
            end
            default: begin
                // Unused width encoding is treated as an illegal access
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  mem_width_e  req_width_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_misaligned_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    // Select the addressed lanes of a read word and sign/zero extend them
    function automatic logic [31:0] extract_load(
        input logic [31:0] rdata,
        input logic [1:0]  idx,
        input mem_width_e  width,
        input logic        is_unsigned
    );
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = rdata >> {idx, 3'b000};
        case (width)
            MEM_BYTE: result = is_unsigned ? {24'h00_0000, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: result = is_unsigned ? {16'h0000, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            MEM_WORD: result = rdata;
            default:  result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    mem_width_e  width_q, width_d;
    logic        uns_q, uns_d;
    logic        write_q, write_d;

    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_mis_q, rsp_mis_d;

    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;

    logic [31:0] prep_addr_s;
    logic [3:0]  prep_strb_s;
    logic [31:0] prep_wdata_s;
    logic        prep_mis_s;
    logic        timeout_s;

    mem_prep u_mem_prep (
        .addr_i       (req_addr_i),
        .width_i      (req_width_i),
        .wdata_i      (req_wdata_i),
        .word_addr_o  (prep_addr_s),
        .strb_o       (prep_strb_s),
        .wdata_o      (prep_wdata_s),
        .misaligned_o (prep_mis_s)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;

    // Count cycles spent in REQ+WAIT; restart whenever a request is accepted
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_IDLE) && req_valid_i) begin
            cnt_d = 8'd0;
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                       ((cnt_q + 8'd1) == TIMEOUT_LIMIT);
`else
    // Without the timeout feature the bus may stall indefinitely
    assign timeout_s = 1'b0;
`endif

    // Next-state, capture and registered-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        width_d     = width_q;
        uns_d       = uns_q;
        write_d     = write_q;
        bus_req_d   = 1'b0;
        bus_addr_d  = 32'h0000_0000;
        bus_we_d    = 1'b0;
        bus_be_d    = 4'b0000;
        bus_wdata_d = 32'h0000_0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        rsp_mis_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    idx_d   = req_addr_i[1:0];
                    width_d = req_width_i;
                    uns_d   = req_unsigned_i;
                    write_d = req_write_i;
                    if (prep_mis_s) begin
                        // Illegal alignment never reaches the bus
                        state_d     = S_FAULT;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = prep_addr_s;
                        bus_we_d    = req_write_i;
                        bus_be_d    = req_write_i ? prep_strb_s : 4'b1111;
                        bus_wdata_d = req_write_i ? prep_wdata_s : 32'h0000_0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (timeout_s) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (bus_gnt_i) begin
                    state_d = S_WAIT;
                end else begin
                    // Hold the request stable until it is granted
                    bus_req_d   = bus_req_q;
                    bus_addr_d  = bus_addr_q;
                    bus_we_d    = bus_we_q;
                    bus_be_d    = bus_be_q;
                    bus_wdata_d = bus_wdata_q;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err_i;
                    rsp_rdata_d = (bus_err_i || write_q) ? 32'h0000_0000
                                : extract_load(bus_rdata_i, idx_q, width_q, uns_q);
                end else if (timeout_s) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'b00;
            width_q     <= MEM_BYTE;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            width_q     <= width_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o      = req_ready_q;
    assign busy_o           = busy_q;
    assign bus_req_o        = bus_req_q;
    assign bus_addr_o       = bus_addr_q;
    assign bus_we_o         = bus_we_q;
    assign bus_be_o         = bus_be_q;
    assign bus_wdata_o      = bus_wdata_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_err_o        = rsp_err_q;
    assign rsp_misaligned_o = rsp_mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scenario tasks with a response scoreboard.
// Timeout scenario is compiled only with LSU_BUS_TIMEOUT_EN.

module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    mem_width_e  req_width_i = MEM_BYTE;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_misaligned_o;
    logic        bus_req_o;
    logic        bus_gnt_i = 1'b0;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_err_i = 1'b0;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        wr;
        mem_width_e  w;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ewd;
        logic [31:0] erd;
    } acc_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(32'd8)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_write_i      (req_write_i),
        .req_width_i      (req_width_i),
        .req_unsigned_i   (req_unsigned_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .rsp_misaligned_o (rsp_misaligned_o),
        .bus_req_o        (bus_req_o),
        .bus_gnt_i        (bus_gnt_i),
        .bus_addr_o       (bus_addr_o),
        .bus_we_o         (bus_we_o),
        .bus_be_o         (bus_be_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_rvalid_i     (bus_rvalid_i),
        .bus_rdata_i      (bus_rdata_i),
        .bus_err_i        (bus_err_i),
        .busy_o           (busy_o)
    );

    task automatic drive_req(input logic wr, input mem_width_e w, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid_i    = 1'b1;
        req_write_i    = wr;
        req_width_i    = w;
        req_unsigned_i = u;
        req_addr_i     = a;
        req_wdata_i    = d;
    endtask

    task automatic clear_inputs();
        req_valid_i  = 1'b0;
        req_write_i  = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        bus_err_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        total_cnt++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready got=%b exp=1", req_ready_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_o); else pass_cnt++;
        total_cnt++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !== 70'h0)
            $display("FAIL rst_bus got=%b/%b/%b/%h/%h exp=all zero", bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o); else pass_cnt++;
        total_cnt++; if ({rsp_valid_o, rsp_err_o, rsp_misaligned_o, rsp_rdata_o} !== 35'h0)
            $display("FAIL rst_rsp got=%b/%b/%b/%h exp=all zero", rsp_valid_o, rsp_err_o, rsp_misaligned_o, rsp_rdata_o); else pass_cnt++;
    endtask

    task automatic test_accesses();
        acc_t tbl[10];
        exp_t e;
        tbl[0] = '{1'b0, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 32'h0000_1000, 4'b1111, 32'h0, 32'hFFFF_FF80};
        tbl[1] = '{1'b0, MEM_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 32'h0000_2000, 4'b1111, 32'h0, 32'h0000_BEEF};
        tbl[2] = '{1'b1, MEM_BYTE, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h5555_AAAA, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB, 32'h0};
        tbl[3] = '{1'b1, MEM_HALF, 1'b0, 32'h0000_3022, 32'hFFFF_1234, 32'h0, 32'h0000_3020, 4'b1100, 32'h1234_1234, 32'h0};
        tbl[4] = '{1'b0, MEM_HALF, 1'b0, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 32'h0000_4000, 4'b1111, 32'h0, 32'hFFFF_8001};
        tbl[5] = '{1'b0, MEM_BYTE, 1'b1, 32'h0000_4001, 32'h0, 32'h0000_F000, 32'h0000_4000, 4'b1111, 32'h0, 32'h0000_00F0};
        tbl[6] = '{1'b0, MEM_WORD, 1'b0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 32'h0000_4004, 4'b1111, 32'h0, 32'hCAFE_F00D};
        tbl[7] = '{1'b0, MEM_BYTE, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_567F, 32'h0000_4000, 4'b1111, 32'h0, 32'h0000_007F};
        tbl[8] = '{1'b1, MEM_WORD, 1'b0, 32'h0000_5008, 32'hDEAD_BEEF, 32'h0, 32'h0000_5008, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        tbl[9] = '{1'b0, MEM_HALF, 1'b0, 32'h0000_4000, 32'h0, 32'hFFFF_7ABC, 32'h0000_4000, 4'b1111, 32'h0, 32'h0000_7ABC};
        for (int i = 0; i < 10; i++) begin
            int dly;
            dly = i % 3;
            drive_req(tbl[i].wr, tbl[i].w, tbl[i].u, tbl[i].a, tbl[i].d);
            exp_q.push_back('{tbl[i].erd, 1'b0, 1'b0});
            @(negedge clk);
            req_valid_i = 1'b0;
            for (int k = 0; k <= dly; k++) begin
                total_cnt++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !== {1'b1, tbl[i].wr, tbl[i].eb, tbl[i].ea})
                    $display("FAIL acc%0d_bus got=%b/%b/%b/%h exp=1/%b/%b/%h", i, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, tbl[i].wr, tbl[i].eb, tbl[i].ea); else pass_cnt++;
                total_cnt++; if ({req_ready_o, busy_o, rsp_valid_o} !== 3'b010)
                    $display("FAIL acc%0d_req_status got=%b%b%b exp=010", i, req_ready_o, busy_o, rsp_valid_o); else pass_cnt++;
                if (tbl[i].wr) begin
                    total_cnt++; if (bus_wdata_o !== tbl[i].ewd)
                        $display("FAIL acc%0d_wdata got=%h exp=%h", i, bus_wdata_o, tbl[i].ewd); else pass_cnt++;
                end
                bus_gnt_i = (k == dly);
                @(negedge clk);
            end
            bus_gnt_i = 1'b0;
            total_cnt++; if ({bus_req_o, rsp_valid_o} !== 2'b00)
                $display("FAIL acc%0d_wait got=%b%b exp=00", i, bus_req_o, rsp_valid_o); else pass_cnt++;
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = tbl[i].rd;
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = 32'h0;
            e = exp_q.pop_front();
            total_cnt++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o} !== {1'b1, e.rdata, e.err, e.mis})
                $display("FAIL acc%0d_rsp got=%b/%h/%b/%b exp=1/%h/%b/%b", i, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o, e.rdata, e.err, e.mis); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if ({rsp_valid_o, req_ready_o} !== 2'b01)
                $display("FAIL acc%0d_after got=%b%b exp=01", i, rsp_valid_o, req_ready_o); else pass_cnt++;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs[2];
        mem_width_e  widths[2];
        logic        wrs[2];
        exp_t        e;
        addrs[0] = 32'h0000_4002; widths[0] = MEM_WORD; wrs[0] = 1'b1;
        addrs[1] = 32'h0000_1001; widths[1] = MEM_HALF; wrs[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_req(wrs[i], widths[i], 1'b0, addrs[i], 32'h1234_5678);
            exp_q.push_back('{32'h0, 1'b1, 1'b1});
            @(negedge clk);
            req_valid_i = 1'b0;
            e = exp_q.pop_front();
            total_cnt++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o} !== {1'b1, e.rdata, e.err, e.mis})
                $display("FAIL mis%0d_rsp got=%b/%h/%b/%b exp=1/%h/%b/%b", i, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o, e.rdata, e.err, e.mis); else pass_cnt++;
            total_cnt++; if (bus_req_o !== 1'b0) $display("FAIL mis%0d_busreq got=%b exp=0", i, bus_req_o); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if ({bus_req_o, rsp_valid_o, req_ready_o} !== 3'b001)
                $display("FAIL mis%0d_after got=%b%b%b exp=001", i, bus_req_o, rsp_valid_o, req_ready_o); else pass_cnt++;
        end
    endtask

    task automatic test_grant_delay();
        exp_t e;
        drive_req(1'b0, MEM_WORD, 1'b0, 32'h0000_6000, 32'h0);
        exp_q.push_back('{32'h0, 1'b1, 1'b0});
        @(negedge clk);
        req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, req_ready_o} !== {1'b1, 1'b0, 4'b1111, 32'h0000_6000, 1'b0})
                $display("FAIL gd_req%0d got=%b/%b/%b/%h/%b exp=1/0/1111/00006000/0", k, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, req_ready_o); else pass_cnt++;
            bus_gnt_i    = (k == 3);
            bus_rvalid_i = (k == 3);
            bus_rdata_i  = 32'h1234_5678;
            @(negedge clk);
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        total_cnt++; if ({bus_req_o, rsp_valid_o, busy_o} !== 3'b001)
            $display("FAIL gd_grant_rvalid_ignored got=%b%b%b exp=001", bus_req_o, rsp_valid_o, busy_o); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL gd_still_wait got=%b exp=0", rsp_valid_o); else pass_cnt++;
        bus_rvalid_i = 1'b1;
        bus_err_i    = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        e = exp_q.pop_front();
        total_cnt++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o} !== {1'b1, e.rdata, e.err, e.mis})
            $display("FAIL gd_buserr got=%b/%h/%b/%b exp=1/%h/%b/%b", rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o, e.rdata, e.err, e.mis); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_req(1'b0, MEM_WORD, 1'b0, 32'h0000_6100, 32'h0);
        exp_q.push_back('{32'h1111_1111, 1'b0, 1'b0});
        exp_q.push_back('{32'h2222_2222, 1'b0, 1'b0});
        @(negedge clk);
        req_addr_i = 32'h0000_6104;
        total_cnt++; if ({bus_req_o, bus_addr_o, req_ready_o} !== {1'b1, 32'h0000_6100, 1'b0})
            $display("FAIL b2b_first_req got=%b/%h/%b exp=1/00006100/0", bus_req_o, bus_addr_o, req_ready_o); else pass_cnt++;
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1111_1111;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        e = exp_q.pop_front();
        total_cnt++; if ({rsp_valid_o, rsp_rdata_o, req_ready_o} !== {1'b1, e.rdata, 1'b0})
            $display("FAIL b2b_first_rsp got=%b/%h/%b exp=1/%h/0", rsp_valid_o, rsp_rdata_o, req_ready_o, e.rdata); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({req_ready_o, rsp_valid_o, bus_req_o} !== 3'b100)
            $display("FAIL b2b_gap got=%b%b%b exp=100", req_ready_o, rsp_valid_o, bus_req_o); else pass_cnt++;
        @(negedge clk);
        req_valid_i = 1'b0;
        total_cnt++; if ({bus_req_o, bus_addr_o, req_ready_o} !== {1'b1, 32'h0000_6104, 1'b0})
            $display("FAIL b2b_second_req got=%b/%h/%b exp=1/00006104/0", bus_req_o, bus_addr_o, req_ready_o); else pass_cnt++;
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h2222_2222;
        @(negedge clk);
        clear_inputs();
        e = exp_q.pop_front();
        total_cnt++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, e.rdata})
            $display("FAIL b2b_second_rsp got=%b/%h exp=1/%h", rsp_valid_o, rsp_rdata_o, e.rdata); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL b2b_end got=%b exp=0", rsp_valid_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Reset while waiting for the response
        drive_req(1'b0, MEM_WORD, 1'b0, 32'h0000_6200, 32'h0);
        @(negedge clk);
        req_valid_i = 1'b0;
        bus_gnt_i   = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        total_cnt++; if (busy_o !== 1'b1) $display("FAIL rm_busy got=%b exp=1", busy_o); else pass_cnt++;
        rst_ni = 1'b0;
        @(negedge clk);
        total_cnt++; if ({busy_o, rsp_valid_o, bus_req_o, req_ready_o} !== 4'b0001)
            $display("FAIL rm_after_rst got=%b%b%b%b exp=0001", busy_o, rsp_valid_o, bus_req_o, req_ready_o); else pass_cnt++;
        rst_ni       = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00)
            $display("FAIL rm_stale got=%b%b exp=00", rsp_valid_o, busy_o); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL rm_stale_late got=%b exp=0", rsp_valid_o); else pass_cnt++;
        // Reset while requesting the bus
        drive_req(1'b0, MEM_WORD, 1'b0, 32'h0000_6300, 32'h0);
        @(negedge clk);
        req_valid_i = 1'b0;
        total_cnt++; if (bus_req_o !== 1'b1) $display("FAIL rm_req got=%b exp=1", bus_req_o); else pass_cnt++;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        total_cnt++; if ({bus_req_o, rsp_valid_o} !== 2'b00)
            $display("FAIL rm_req_drop got=%b%b exp=00", bus_req_o, rsp_valid_o); else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef LSU_BUS_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit   got;
        int   lat;
        drive_req(1'b0, MEM_WORD, 1'b0, 32'h0000_7000, 32'h0);
        exp_q.push_back('{32'h0, 1'b1, 1'b0});
        @(negedge clk);
        req_valid_i = 1'b0;
        got = 1'b0;
        lat = 1;
        while (!got && (lat < 40)) begin
            if (rsp_valid_o === 1'b1) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        total_cnt++; if (got !== 1'b1) $display("FAIL to_no_response got=%b exp=1 after %0d cycles", got, lat); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o, bus_req_o} !== {1'b1, e.rdata, e.err, e.mis, 1'b0})
            $display("FAIL to_rsp got=%b/%h/%b/%b/%b exp=1/%h/%b/%b/0", rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_misaligned_o, bus_req_o, e.rdata, e.err, e.mis); else pass_cnt++;
        @(negedge clk);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hABCD_0123;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        total_cnt++; if ({rsp_valid_o, busy_o} !== 2'b00)
            $display("FAIL to_late_rvalid got=%b%b exp=00", rsp_valid_o, busy_o); else pass_cnt++;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_accesses();
        test_misaligned();
        test_grant_delay();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_BUS_TIMEOUT_EN
        test_timeout();
`endif
        total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
